// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store sequencer feeding the word-addressed
// data memory. Forms ea = base + sext(offset), drives MemR/MemW from registered
// state, captures load data into LMD and pulses done on completion.
// Optional feature macro: MEM_ACCESS_BOUNDS_CHECK_EN (fault on ea[31:10] != 0).
module mem_access_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic [5:0]  req_opcode,
   input  logic [31:0] req_base,
   input  logic [15:0] req_offset,
   input  logic [31:0] req_wdata,
   output logic [5:0]  mem_opcode,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_r,
   output logic        mem_w,
   input  logic [31:0] mem_rdata,
   output logic [31:0] lmd,
   output logic        done,
   output logic        fault
);

   localparam int unsigned DW = 32;
   localparam int unsigned OW = 16;

   typedef enum logic [1:0] {IDLE, ADDR, READ, DONE} state_t;

   state_t       state;
   logic         load_q;
   logic         bad_q;
   logic         bad_c;
   logic [DW-1:0] ea_c;

   // Effective address, wraps modulo 2^32
   assign ea_c = req_base + {{(DW-OW){req_offset[OW-1]}}, req_offset};

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
   logic fault_q;

   // Any address bit above the 10-bit word index is out of range
   assign bad_c = |ea_c[DW-1:10];
   assign fault = fault_q;
`else
   assign bad_c = 1'b0;
   assign fault = 1'b0;
`endif

   // Sequencer FSM with registered memory-side controls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         load_q     <= 1'b0;
         bad_q      <= 1'b0;
         mem_opcode <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_r      <= 1'b0;
         mem_w      <= 1'b0;
         lmd        <= '0;
         done       <= 1'b0;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state      <= ADDR;
                  req_ready  <= 1'b0;
                  load_q     <= req_load;
                  bad_q      <= bad_c;
                  mem_opcode <= req_opcode;
                  mem_addr   <= ea_c;
                  mem_wdata  <= req_wdata;
                  // Strobes are registered here so they are high for the whole ADDR cycle
                  mem_r      <= req_load & ~bad_c;
                  mem_w      <= ~req_load & ~bad_c;
               end
            end
            ADDR: begin
               mem_w <= 1'b0;
               if (load_q && !bad_q) begin
                  state <= READ;
               end else begin
                  // Store complete, or faulting access skipped
                  state <= DONE;
                  mem_r <= 1'b0;
                  done  <= 1'b1;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
                  fault_q <= bad_q;
`endif
               end
            end
            READ: begin
               state <= DONE;
               mem_r <= 1'b0;
               lmd   <= mem_rdata;
               done  <= 1'b1;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
               fault_q <= 1'b0;
`endif
            end
            DONE: begin
               state     <= IDLE;
               done      <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               mem_r     <= 1'b0;
               mem_w     <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 1024-word memory.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_load;
   logic [5:0]  req_opcode;
   logic [31:0] req_base;
   logic [15:0] req_offset;
   logic [31:0] req_wdata;
   logic [5:0]  mem_opcode;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_r;
   logic        mem_w;
   logic [31:0] mem_rdata;
   logic [31:0] lmd;
   logic        done;
   logic        fault;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] tb_mem [1024];
   bit          mem_init = 1'b0;

   mem_access_unit dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
      .req_opcode(req_opcode), .req_base(req_base), .req_offset(req_offset),
      .req_wdata(req_wdata),
      .mem_opcode(mem_opcode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_r(mem_r), .mem_w(mem_w), .mem_rdata(mem_rdata),
      .lmd(lmd), .done(done), .fault(fault)
   );

   always #5 clk = ~clk;

   // Memory model: word i initialised to 0xA5000000|i, synchronous write, async read
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'hA500_0000 | 32'(i);
         mem_init <= 1'b1;
      end else if (mem_w) begin
         tb_mem[mem_addr[9:0]] <= mem_wdata;
      end
   end

   assign mem_rdata = mem_init ? tb_mem[mem_addr[9:0]] : 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   int   rcnt;
   logic ovl;
   logic [5:0] wseen;
   logic [5:0] dseen;
   logic [5:0] rdy;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_opcode = '0;
      req_base = '0; req_offset = '0; req_wdata = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_lmd", lmd, 32'd0);
      check("rst_mem_r", 32'(mem_r), 32'd0);
      check("rst_mem_w", 32'(mem_w), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Store 0xDEADBEEF to 0x100+4
      req_valid = 1'b1; req_load = 1'b0; req_opcode = 6'h2B;
      req_base = 32'h100; req_offset = 16'h0004; req_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      req_valid = 1'b0;
      check("st_e0_mem_w", 32'(mem_w), 32'd1);
      check("st_e0_mem_r", 32'(mem_r), 32'd0);
      check("st_e0_addr", mem_addr, 32'h104);
      check("st_e0_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("st_e0_opcode", 32'(mem_opcode), 32'h2B);
      check("st_e0_ready", 32'(req_ready), 32'd0);
      check("st_e0_done", 32'(done), 32'd0);
      @(negedge clk);
      check("st_e1_mem_w", 32'(mem_w), 32'd0);
      check("st_e1_done", 32'(done), 32'd1);
      check("st_e1_addr_hold", mem_addr, 32'h104);
      @(negedge clk);
      check("st_e2_done", 32'(done), 32'd0);
      check("st_e2_ready", 32'(req_ready), 32'd1);
      check("st_mem_word", tb_mem[10'h104], 32'hDEAD_BEEF);

      // Load back from 0x104
      req_valid = 1'b1; req_load = 1'b1; req_opcode = 6'h23;
      @(negedge clk);
      req_valid = 1'b0;
      check("ld_e0_mem_r", 32'(mem_r), 32'd1);
      check("ld_e0_mem_w", 32'(mem_w), 32'd0);
      check("ld_e0_done", 32'(done), 32'd0);
      @(negedge clk);
      check("ld_e1_mem_r", 32'(mem_r), 32'd1);
      check("ld_e1_done", 32'(done), 32'd0);
      @(negedge clk);
      check("ld_e2_mem_r", 32'(mem_r), 32'd0);
      check("ld_e2_done", 32'(done), 32'd1);
      check("ld_e2_lmd", lmd, 32'hDEAD_BEEF);
      check("ld_e2_fault", 32'(fault), 32'd0);
      @(negedge clk);
      check("ld_e3_done", 32'(done), 32'd0);
      check("ld_e3_ready", 32'(req_ready), 32'd1);

      // Negative offset: 0x10 + (-4) = 0x0C
      req_valid = 1'b1; req_load = 1'b1; req_base = 32'h10; req_offset = 16'hFFFC;
      @(negedge clk);
      req_valid = 1'b0;
      check("neg_addr", mem_addr, 32'h0000_000C);
      rcnt = 32'(mem_r);
      repeat (3) begin
         @(negedge clk);
         rcnt += 32'(mem_r);
      end
      check("neg_mem_r_cycles", 32'(rcnt), 32'd2);
      check("neg_lmd", lmd, 32'hA500_000C);

      // Back-to-back load then store with req_valid held high
      req_valid = 1'b1; req_load = 1'b1; req_base = 32'h20; req_offset = 16'h0;
      ovl = 1'b0; wseen = '0; dseen = '0; rdy = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) begin
            req_load = 1'b0; req_base = 32'h30; req_wdata = 32'h0000_0055;
         end
         if (k == 4) req_valid = 1'b0;
         ovl      = ovl | (mem_r & mem_w);
         wseen[k] = mem_w;
         dseen[k] = done;
         rdy[k]   = req_ready;
      end
      check("b2b_overlap", 32'(ovl), 32'd0);
      check("b2b_done_pattern", 32'(dseen), 32'b100100);
      check("b2b_mem_w_pattern", 32'(wseen), 32'b010000);
      check("b2b_ready_pattern", 32'(rdy), 32'b001000);
      @(negedge clk);
      check("b2b_store_word", tb_mem[10'h30], 32'h0000_0055);
      check("b2b_lmd", lmd, 32'hA500_0020);

      // Reset pulsed during a load's READ cycle
      req_valid = 1'b1; req_load = 1'b1; req_base = 32'h40; req_offset = 16'h0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("rr_pre_mem_r", 32'(mem_r), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rr_mem_r", 32'(mem_r), 32'd0);
      check("rr_lmd", lmd, 32'd0);
      check("rr_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      dseen = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         dseen[k] = done;
      end
      check("rr_no_done", 32'(dseen), 32'd0);
      check("rr_lmd_hold", lmd, 32'd0);

      // Out-of-range store, ea = 0x400
      req_valid = 1'b1; req_load = 1'b0; req_base = 32'h400; req_offset = 16'h0;
      req_wdata = 32'h0000_0077;
      @(negedge clk);
      req_valid = 1'b0;
      check("oob_mem_w", 32'(mem_w), BC ? 32'd0 : 32'd1);
      @(negedge clk);
      check("oob_done", 32'(done), 32'd1);
      check("oob_fault", 32'(fault), BC ? 32'd1 : 32'd0);
      @(negedge clk);
      check("oob_word0", tb_mem[0], BC ? 32'hA500_0000 : 32'h0000_0077);
      check("oob_fault_hold", 32'(fault), BC ? 32'd1 : 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
